// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register: in_ready comes from registered state only, so out_ready has no combinational path upstream.
// Optional synchronous flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             take;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // State and data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and data
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && take) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef PIPE_SKID_FLUSH_EN
    // Flush wins over any same-cycle accept or take
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
`endif
  end

  // Outputs decoded from registered state
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_data  = main_q;
    case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_skid_reg;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered list of held words plus the word last shown on out_data
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_last;

  pipe_skid_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_last = '0;
  endtask

  // Check outputs against the model mid-cycle, advance the model, then step past the edge
  task automatic cycle();
    bit acc;
    bit tk;
    @(negedge clk);
    check_eq("mdl_valid", WIDTH'(out_valid), WIDTH'(mq.size() > 0));
    check_eq("mdl_ready", WIDTH'(in_ready), WIDTH'(mq.size() < 2));
    check_eq("mdl_data", out_data, (mq.size() > 0) ? mq[0] : m_last);
    acc = in_valid && (mq.size() < 2);
    tk  = out_ready && (mq.size() > 0);
`ifdef PIPE_SKID_FLUSH_EN
    if (flush) begin
      model_clear();
      acc = 1'b0;
      tk  = 1'b0;
    end
`endif
    if (tk) void'(mq.pop_front());
    if (acc) mq.push_back(in_data);
    if (mq.size() > 0) m_last = mq[0];
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic reset_mid();
    #1 reset = 1'b1;
    #1;
    check_eq("rst_valid", WIDTH'(out_valid), WIDTH'(0));
    check_eq("rst_ready", WIDTH'(in_ready), WIDTH'(1));
    check_eq("rst_data", out_data, WIDTH'(0));
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic v, input logic [WIDTH-1:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    cycle();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    #3;
    check_eq("por_valid", WIDTH'(out_valid), WIDTH'(0));
    check_eq("por_ready", WIDTH'(in_ready), WIDTH'(1));
    check_eq("por_data", out_data, WIDTH'(0));
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming with out_ready high
    send(1'b1, 32'h1111_1111, 1'b1);
    check_eq("strm_d1", out_data, 32'h1111_1111);
    check_eq("strm_r1", WIDTH'(in_ready), WIDTH'(1));
    send(1'b1, 32'h2222_2222, 1'b1);
    check_eq("strm_d2", out_data, 32'h2222_2222);
    check_eq("strm_r2", WIDTH'(in_ready), WIDTH'(1));
    send(1'b1, 32'h3333_3333, 1'b1);
    check_eq("strm_d3", out_data, 32'h3333_3333);
    check_eq("strm_r3", WIDTH'(in_ready), WIDTH'(1));
    send(1'b0, '0, 1'b1);
    check_eq("strm_drain", WIDTH'(out_valid), WIDTH'(0));

    // Backpressure fills main then skid
    send(1'b1, 32'hA0, 1'b0);
    send(1'b1, 32'hB0, 1'b0);
    check_eq("bp_ready", WIDTH'(in_ready), WIDTH'(0));
    check_eq("bp_data", out_data, 32'hA0);
    check_eq("bp_valid", WIDTH'(out_valid), WIDTH'(1));
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 32'hC0, 1'b0);
      check_eq("full_hold", out_data, 32'hA0);
    end
    send(1'b0, '0, 1'b1);
    check_eq("bp_take1", out_data, 32'hB0);
    check_eq("bp_ready2", WIDTH'(in_ready), WIDTH'(1));
    send(1'b0, '0, 1'b1);
    check_eq("bp_empty", WIDTH'(out_valid), WIDTH'(0));

`ifdef PIPE_SKID_FLUSH_EN
    send(1'b1, 32'hA0, 1'b0);
    send(1'b1, 32'hB0, 1'b0);
    flush = 1'b1;
    send(1'b1, 32'hD0, 1'b0);
    flush = 1'b0;
    check_eq("fl_valid", WIDTH'(out_valid), WIDTH'(0));
    check_eq("fl_ready", WIDTH'(in_ready), WIDTH'(1));
    check_eq("fl_data", out_data, WIDTH'(0));
    for (int i = 0; i < 3; i++) begin
      send(1'b0, '0, 1'b1);
      check_eq("fl_gone", WIDTH'(out_valid), WIDTH'(0));
    end
`endif

    // Reset while holding a word
    send(1'b1, 32'h55, 1'b0);
    check_eq("rb_hold", out_data, 32'h55);
    reset_mid();
    send(1'b1, 32'h66, 1'b0);
    check_eq("rb_new", out_data, 32'h66);
    send(1'b0, '0, 1'b1);
    check_eq("rb_empty", WIDTH'(out_valid), WIDTH'(0));
    check_eq("rb_last", out_data, 32'h66);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(99) < 60);
      in_data   = WIDTH'($urandom());
      out_ready = ($urandom_range(99) < 55);
`ifdef PIPE_SKID_FLUSH_EN
      flush     = ($urandom_range(99) < 2);
`endif
      if ($urandom_range(299) == 0) reset_mid();
      cycle();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
